// File: rtl/data_memory_sized_if.sv
`default_nettype none
// =============================================================================
// Interface : data_memory_sized_if
// Brief     : Request/response bundle between the CPU datapath and data memory.
// Revision  : 1.0 - initial release
// =============================================================================
interface data_memory_sized_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] address;
    logic [31:0]       write_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       read_data;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, address, write_data, rsp_ready,
        input  req_ready, rsp_valid, read_data, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, address, write_data, rsp_ready,
        output req_ready, rsp_valid, read_data, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/data_memory_sized.sv
`default_nettype none
// =============================================================================
// Module   : data_memory_sized
// Brief    : Byte/half/word data memory with lane enables, load extension,
//            error detection and a one-entry registered response stage.
// Revision : 1.0 - initial release
// =============================================================================
module data_memory_sized #(
    parameter int DEPTH     = 128,
    parameter int ADDR_W    = 32,
    parameter bit INIT_ZERO = 1'b1
) (
    input  wire logic           clk,
    input  wire logic           rst,
    data_memory_sized_if.slave  bus
);
    localparam int c_IDX_W = $clog2(DEPTH);
    localparam int c_AW    = c_IDX_W + 2;

    localparam logic [0:0] c_ST_EMPTY = 1'b0;
    localparam logic [0:0] c_ST_FULL  = 1'b1;

    logic [0:0]         r_state;
    logic [31:0]        r_read_data;
    logic               r_rsp_err;

    logic               w_req_ready;
    logic               w_accept;
    logic [1:0]         w_lane;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_oob;
    logic               w_misalign;
    logic               w_err;
    logic               w_we;
    logic [3:0]         w_strb;
    logic [31:0]        w_wlanes;
    logic [31:0]        w_rd_word;
    logic [31:0]        w_shifted;
    logic [31:0]        w_load_data;
    logic [31:0]        w_rsp_data;

    assign w_req_ready = (r_state == c_ST_EMPTY) || bus.rsp_ready;
    assign w_accept    = bus.req_valid && w_req_ready;
    assign w_lane      = bus.address[1:0];
    assign w_idx       = bus.address[c_AW-1:2];

    generate
        if (ADDR_W > c_AW) begin : g_oob
            assign w_oob = |bus.address[ADDR_W-1:c_AW];
        end else begin : g_no_oob
            assign w_oob = 1'b0;
        end
    endgenerate

    always_comb begin
        w_misalign = 1'b0;
        case (bus.req_size)
            2'b01:   w_misalign = w_lane[0];
            2'b10:   w_misalign = |w_lane;
            default: w_misalign = 1'b0;
        endcase
    end

    assign w_err = (bus.req_size == 2'b11) || w_misalign || w_oob;
    // Reset masks the write so a request presented alongside rst leaves memory intact
    assign w_we  = w_accept && bus.req_we && !w_err && !rst;

    always_comb begin
        w_strb   = 4'b0000;
        w_wlanes = bus.write_data;
        case (bus.req_size)
            2'b00: begin
                w_strb   = 4'b0001 << w_lane;
                w_wlanes = {4{bus.write_data[7:0]}};
            end
            2'b01: begin
                w_strb   = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{bus.write_data[15:0]}};
            end
            2'b10:   w_strb = 4'b1111;
            default: w_strb = 4'b0000;
        endcase
    end

    generate
        if (INIT_ZERO) begin : g_mem_zero
            logic [31:0] r_mem [DEPTH] = '{default: '0};

            always_ff @(posedge clk) begin
                if (w_we) begin
                    for (int l = 0; l < 4; l++) begin
                        if (w_strb[l]) begin
                            r_mem[w_idx][8*l +: 8] <= w_wlanes[8*l +: 8];
                        end
                    end
                end
            end

            assign w_rd_word = r_mem[w_idx];
        end else begin : g_mem_undef
            logic [31:0] r_mem [DEPTH];

            always_ff @(posedge clk) begin
                if (w_we) begin
                    for (int l = 0; l < 4; l++) begin
                        if (w_strb[l]) begin
                            r_mem[w_idx][8*l +: 8] <= w_wlanes[8*l +: 8];
                        end
                    end
                end
            end

            assign w_rd_word = r_mem[w_idx];
        end
    endgenerate

    assign w_shifted = w_rd_word >> {w_lane, 3'b000};

    always_comb begin
        w_load_data = w_shifted;
        case (bus.req_size)
            2'b00:   w_load_data = {{24{~bus.req_unsigned & w_shifted[7]}}, w_shifted[7:0]};
            2'b01:   w_load_data = {{16{~bus.req_unsigned & w_shifted[15]}}, w_shifted[15:0]};
            default: w_load_data = w_shifted;
        endcase
    end

    assign w_rsp_data = (w_err || bus.req_we) ? 32'h0 : w_load_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_EMPTY;
            r_read_data <= 32'h0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_EMPTY: begin
                    if (w_accept) begin
                        r_state     <= c_ST_FULL;
                        r_read_data <= w_rsp_data;
                        r_rsp_err   <= w_err;
                    end
                end
                c_ST_FULL: begin
                    // Drain and refill in one cycle keeps the stage full
                    if (w_accept) begin
                        r_read_data <= w_rsp_data;
                        r_rsp_err   <= w_err;
                    end else if (bus.rsp_ready) begin
                        r_state <= c_ST_EMPTY;
                    end
                end
                default: r_state <= c_ST_EMPTY;
            endcase
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = (r_state == c_ST_FULL);
    assign bus.read_data = r_read_data;
    assign bus.rsp_err   = r_rsp_err;
endmodule
`default_nettype wire

// File: tb/tb_data_memory_sized.sv
`default_nettype none
// =============================================================================
// Module   : tb_data_memory_sized
// Brief    : Self-checking bench for data_memory_sized against a byte-array model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_data_memory_sized;
    localparam int c_DEPTH = 128;
    localparam int c_AW    = $clog2(c_DEPTH) + 2;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [7:0] ref_mem [c_DEPTH*4];

    data_memory_sized_if #(.ADDR_W(32)) bus ();

    data_memory_sized #(
        .DEPTH     (c_DEPTH),
        .ADDR_W    (32),
        .INIT_ZERO (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic logic model_err(input logic [1:0] size, input logic [31:0] a);
        if (size == 2'd3) return 1'b1;
        if (a >= 32'(c_DEPTH * 4)) return 1'b1;
        return (a % (32'd1 << size)) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                               input logic [31:0] a);
        int          n;
        logic [31:0] v;
        n = 1 << size;
        v = 32'h0;
        for (int k = 0; k < n; k++) v = v | (32'(ref_mem[a + 32'(k)]) << (8 * k));
        if (n < 4 && !uns && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    function automatic void model_store(input logic [1:0] size, input logic [31:0] a,
                                        input logic [31:0] wd);
        int n;
        n = 1 << size;
        for (int k = 0; k < n; k++) ref_mem[a + 32'(k)] = 8'(wd >> (8 * k));
    endfunction

    // Expected response for one request; commits stores into the model.
    function automatic void model_op(input logic we, input logic [1:0] size, input logic uns,
                                     input logic [31:0] a, input logic [31:0] wd,
                                     output logic [31:0] rd, output logic er);
        er = model_err(size, a);
        rd = (er || we) ? 32'h0 : model_load(size, uns, a);
        if (we && !er) model_store(size, a, wd);
    endfunction

    task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.address      = a;
        bus.write_data   = wd;
    endtask

    // One request with rsp_ready=1; samples the response just after the accept edge.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output logic got);
        int cyc;
        @(negedge clk);
        drive(we, size, uns, a, wd);
        bus.req_valid = 1'b1;
        bus.rsp_ready = 1'b1;
        cyc = 0;
        while (!bus.req_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        got = bus.rsp_valid;
        rd  = bus.read_data;
        er  = bus.rsp_err;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid);
        end
        checks++;
        if (bus.read_data !== 32'h0 || bus.rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got data=%h err=%b expected data=0 err=0",
                     bus.read_data, bus.rsp_err);
        end
        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_store_load_word();
        logic [31:0] rd, exp_rd;
        logic        er, exp_er, got;
        logic        we  [2] = '{1'b1, 1'b0};
        for (int i = 0; i < 2; i++) begin
            issue(we[i], 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, rd, er, got);
            model_op(we[i], 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, exp_rd, exp_er);
            checks++;
            if (got !== 1'b1 || rd !== exp_rd || er !== exp_er) begin
                failures++;
                $display("FAIL word_op%0d: got v=%b d=%h e=%b expected v=1 d=%h e=%b",
                         i, got, rd, er, exp_rd, exp_er);
            end
        end
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL word_readback: got %h expected deadbeef", rd);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd, exp_rd;
        logic        er, exp_er, got;
        logic        we   [7] = '{1, 0, 0, 0, 1, 0, 0};
        logic [1:0]  sz   [7] = '{0, 0, 0, 2, 1, 1, 1};
        logic        uns  [7] = '{0, 0, 1, 0, 0, 0, 1};
        logic [31:0] ad   [7] = '{32'h13, 32'h13, 32'h13, 32'h10, 32'h16, 32'h16, 32'h16};
        logic [31:0] wd   [7] = '{32'h1234_5680, 0, 0, 0, 32'hAAAA_9ABC, 0, 0};
        logic [31:0] abs_v [7] = '{0, 32'hFFFF_FF80, 32'h0000_0080, 32'h80AD_BEEF,
                                   0, 32'hFFFF_9ABC, 32'h0000_9ABC};
        for (int i = 0; i < 7; i++) begin
            issue(we[i], sz[i], uns[i], ad[i], wd[i], rd, er, got);
            model_op(we[i], sz[i], uns[i], ad[i], wd[i], exp_rd, exp_er);
            checks++;
            if (got !== 1'b1 || rd !== exp_rd || er !== exp_er) begin
                failures++;
                $display("FAIL lane_op%0d: got v=%b d=%h e=%b expected v=1 d=%h e=%b",
                         i, got, rd, er, exp_rd, exp_er);
            end
            checks++;
            if (rd !== abs_v[i]) begin
                failures++;
                $display("FAIL lane_value%0d: got %h expected %h", i, rd, abs_v[i]);
            end
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd, exp_rd;
        logic        er, exp_er, got;
        logic        we  [8] = '{0, 0, 0, 0, 1, 1, 0, 0};
        logic [1:0]  sz  [8] = '{1, 2, 3, 2, 2, 1, 2, 2};
        logic [31:0] ad  [8] = '{32'h11, 32'h12, 32'h0, 32'(c_DEPTH * 4),
                                 32'(c_DEPTH * 4), 32'h11, 32'h0, 32'h10};
        logic        eer [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
        for (int i = 0; i < 8; i++) begin
            issue(we[i], sz[i], 1'b0, ad[i], 32'h5555_1111, rd, er, got);
            model_op(we[i], sz[i], 1'b0, ad[i], 32'h5555_1111, exp_rd, exp_er);
            checks++;
            if (got !== 1'b1 || rd !== exp_rd || er !== exp_er || er !== eer[i]) begin
                failures++;
                $display("FAIL err_op%0d: got v=%b d=%h e=%b expected v=1 d=%h e=%b",
                         i, got, rd, er, exp_rd, eer[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd, exp_rd, hold_rd;
        logic        er, exp_er, got;
        @(negedge clk);
        drive(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        bus.req_valid = 1'b1;
        bus.rsp_ready = 1'b0;
        model_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, hold_rd, exp_er);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.read_data !== hold_rd) begin
            failures++;
            $display("FAIL bp_first: got v=%b d=%h expected v=1 d=%h",
                     bus.rsp_valid, bus.read_data, hold_rd);
        end
        // A store offered while stalled and then withdrawn must never land
        @(negedge clk);
        drive(1'b1, 2'd2, 1'b0, 32'h20, 32'hA5A5_A5A5);
        bus.req_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b1 ||
                bus.read_data !== hold_rd || bus.rsp_err !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold%0d: got rdy=%b v=%b d=%h e=%b expected rdy=0 v=1 d=%h e=0",
                         c, bus.req_ready, bus.rsp_valid, bus.read_data, bus.rsp_err, hold_rd);
            end
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain: got v=%b expected 0", bus.rsp_valid);
        end
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er, got);
        model_op(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, exp_rd, exp_er);
        checks++;
        if (got !== 1'b1 || rd !== exp_rd || er !== exp_er) begin
            failures++;
            $display("FAIL bp_untouched: got v=%b d=%h e=%b expected v=1 d=%h e=%b",
                     got, rd, er, exp_rd, exp_er);
        end
        issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h5A5A_1234, rd, er, got);
        model_op(1'b1, 2'd2, 1'b0, 32'h20, 32'h5A5A_1234, exp_rd, exp_er);
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er, got);
        model_op(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, exp_rd, exp_er);
        checks++;
        if (got !== 1'b1 || rd !== exp_rd || er !== exp_er) begin
            failures++;
            $display("FAIL bp_written: got v=%b d=%h e=%b expected v=1 d=%h e=%b",
                     got, rd, er, exp_rd, exp_er);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_rd, a;
        logic        exp_er, we, uns;
        logic [1:0]  sz;
        logic [31:0] base;
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        base = 32'h40;
        for (int i = 0; i < 20; i++) begin
            we  = (i % 2) == 0;
            if (we) base = 32'h40 + 4 * $urandom_range(0, 7);
            sz  = 2'($urandom_range(0, 2));
            uns = 1'($urandom_range(0, 1));
            a   = base + ((sz == 2'd2) ? 0 : (sz == 2'd1) ? 2 * $urandom_range(0, 1)
                                                          : $urandom_range(0, 3));
            drive(we, sz, uns, a, $urandom);
            bus.req_valid = 1'b1;
            model_op(we, sz, uns, a, bus.write_data, exp_rd, exp_er);
            @(posedge clk);
            #1;
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b1 ||
                bus.read_data !== exp_rd || bus.rsp_err !== exp_er) begin
                failures++;
                $display("FAIL b2b_op%0d: got v=%b rdy=%b d=%h e=%b expected v=1 rdy=1 d=%h e=%b",
                         i, bus.rsp_valid, bus.req_ready, bus.read_data, bus.rsp_err,
                         exp_rd, exp_er);
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] rd, exp_rd, a, wd;
        logic        er, exp_er, got, we, uns;
        logic [1:0]  sz;
        for (int i = 0; i < 80; i++) begin
            we  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 3));
            a   = 32'($urandom_range(0, c_DEPTH * 4 - 1));
            if ($urandom_range(0, 4) == 0) a = a | (32'd1 << $urandom_range(c_AW, 31));
            wd  = $urandom;
            issue(we, sz, uns, a, wd, rd, er, got);
            model_op(we, sz, uns, a, wd, exp_rd, exp_er);
            checks++;
            if (got !== 1'b1 || rd !== exp_rd || er !== exp_er) begin
                failures++;
                $display("FAIL rand_op%0d we=%b sz=%0d a=%h: got v=%b d=%h e=%b expected v=1 d=%h e=%b",
                         i, we, sz, a, got, rd, er, exp_rd, exp_er);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, exp_rd;
        logic        er, exp_er, got;
        @(negedge clk);
        drive(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        bus.req_valid = 1'b1;
        bus.rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre: got v=%b expected 1", bus.rsp_valid);
        end
        @(negedge clk);
        drive(1'b1, 2'd2, 1'b0, 32'h20, 32'h0BAD_F00D);
        bus.req_valid = 1'b1;
        bus.rsp_ready = 1'b1;
        rst           = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.read_data !== 32'h0 || bus.rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_drop: got v=%b d=%h e=%b expected v=0 d=0 e=0",
                     bus.rsp_valid, bus.read_data, bus.rsp_err);
        end
        @(negedge clk);
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er, got);
        model_op(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, exp_rd, exp_er);
        checks++;
        if (got !== 1'b1 || rd !== exp_rd || er !== exp_er || rd !== 32'h5A5A_1234) begin
            failures++;
            $display("FAIL rstmid_keep: got v=%b d=%h e=%b expected v=1 d=%h e=%b",
                     got, rd, er, exp_rd, exp_er);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < c_DEPTH * 4; i++) ref_mem[i] = 8'h00;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        drive(1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        test_reset();
        test_store_load_word();
        test_byte_lanes();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
